// File: rtl/alu_operand_arbiter_pkg.sv
// Shared definitions for the ALU operand arbiter.
//   DATA_W       : operand width; fixed by the 2:1 gate-level mux.
//   SRC_A/SRC_B  : encoding of out_src and last_src.
//   state_t      : output-register occupancy state.
package alu_operand_arbiter_pkg;

    localparam int DATA_W = 32;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/mux2w32.sv
// Gate-level 2:1 multiplexer, 32 bits wide.
//   a   : data selected when sel = 0
//   b   : data selected when sel = 1
//   sel : select
//   y   : selected data
module mux2w32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sel,
    output logic [31:0] y
);

    assign y = (a & {32{~sel}}) | (b & {32{sel}});

endmodule

// File: rtl/alu_operand_arbiter.sv
// Round-robin arbiter sharing the ALU operand path between requesters A and B.
// The winner's operand goes through a 2:1 mux into a one-entry output register
// that feeds the ALU.
//
// Handshake: on every channel a transfer happens on a rising clk edge where
// valid and ready are both high. Ready may depend on valid in the same cycle;
// valid never depends on ready.
//
// Ports:
//   clk, rst               : clock (rising edge), async active-high reset
//   a_valid/a_data/a_ready : requester A channel
//   b_valid/b_data/b_ready : requester B channel
//   out_valid/out_data     : registered operand towards the ALU
//   out_src                : source of out_data (0 = A, 1 = B)
//   out_ready              : ALU consumes out_data this cycle
//   cnt_clr                : synchronous clear of both grant counters
//   grant_cnt_a/_b         : saturating grant counters
module alu_operand_arbiter
    import alu_operand_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  grant_cnt_a,
    output logic [CNT_W-1:0]  grant_cnt_b
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic              last_src;
    logic              grant_a;
    logic              grant_b;
    logic              can_load;
    logic              load;
    logic [DATA_W-1:0] mux_y;

    // Contention goes to the side that did not win last time.
    assign grant_a  = a_valid & (~b_valid | (last_src == SRC_B));
    assign grant_b  = b_valid & (~a_valid | (last_src == SRC_A));
    assign can_load = (state == ST_EMPTY) | out_ready;

    // rst gating keeps both readies low while the flops are held in reset.
    assign a_ready  = grant_a & can_load & ~rst;
    assign b_ready  = grant_b & can_load & ~rst;
    assign load     = a_ready | b_ready;

    assign out_valid = (state == ST_FULL);

    mux2w32 u_mux (
        .a   (a_data),
        .b   (b_data),
        .sel (grant_b),
        .y   (mux_y)
    );

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = ST_FULL;
        end else if ((state == ST_FULL) && out_ready) begin
            state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_src  <= SRC_A;
            last_src <= SRC_B;
        end else begin
            state <= state_nxt;
            if (load) begin
                out_data <= mux_y;
                out_src  <= grant_b;
                last_src <= grant_b;
            end
        end
    end

    // Clear wins over increment; counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_a <= '0;
            grant_cnt_b <= '0;
        end else if (cnt_clr) begin
            grant_cnt_a <= '0;
            grant_cnt_b <= '0;
        end else begin
            if (a_ready && (grant_cnt_a != CNT_MAX)) begin
                grant_cnt_a <= grant_cnt_a + CNT_ONE;
            end
            if (b_ready && (grant_cnt_b != CNT_MAX)) begin
                grant_cnt_b <= grant_cnt_b + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_arbiter.sv
module tb_alu_operand_arbiter;

  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              a_valid = 1'b0;
  logic [31:0]       a_data = '0;
  logic              a_ready;
  logic              b_valid = 1'b0;
  logic [31:0]       b_data = '0;
  logic              b_ready;
  logic              out_valid;
  logic [31:0]       out_data;
  logic              out_src;
  logic              out_ready = 1'b0;
  logic              cnt_clr = 1'b0;
  logic [CNT_W-1:0]  grant_cnt_a;
  logic [CNT_W-1:0]  grant_cnt_b;

  int n_cmp  = 0;
  int n_fail = 0;

  // expected {src, data} for each operand the ALU should consume
  logic [32:0] exp_q[$];

  alu_operand_arbiter #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_ready   (out_ready),
    .cnt_clr     (cnt_clr),
    .grant_cnt_a (grant_cnt_a),
    .grant_cnt_b (grant_cnt_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  // monitor: samples on the falling edge, where a transfer to the ALU is decided
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL out_unexpected: got src=%0d data=0x%08h expected nothing", out_src, out_data);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("out_operand", {31'd0, out_src, out_data}, {31'd0, e});
      end
    end
  end

  initial begin
    // reset state, ready held low during reset even with a request
    a_valid = 1'b1;
    #1;
    check("rst_a_ready", a_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_cnt_a", grant_cnt_a, 0);
    check("rst_cnt_b", grant_cnt_b, 0);
    a_valid = 1'b0;
    step();
    step();
    rst = 1'b0;

    // A only
    a_valid = 1'b1; a_data = 32'h0000_1234; out_ready = 1'b1;
    #1;
    check("t1_a_ready", a_ready, 1);
    check("t1_b_ready", b_ready, 0);
    exp_q.push_back({1'b0, 32'h0000_1234});
    step();
    a_valid = 1'b0;
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 32'h0000_1234);
    check("t1_out_src", out_src, 0);
    check("t1_cnt_a", grant_cnt_a, 1);
    step();

    // both valid: strict alternation from A after reset
    do_reset();
    a_valid = 1'b1; a_data = 32'hAAAA_AAAA;
    b_valid = 1'b1; b_data = 32'h5555_5555;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t2_a_ready", a_ready, (i % 2 == 0));
      check("t2_b_ready", b_ready, (i % 2 == 1));
      if (i % 2 == 0) exp_q.push_back({1'b0, 32'hAAAA_AAAA});
      else            exp_q.push_back({1'b1, 32'h5555_5555});
      step();
      check("t2_no_bubble", out_valid, 1);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("t2_cnt_a", grant_cnt_a, 3);
    check("t2_cnt_b", grant_cnt_b, 3);

    // drain to empty, data held
    step();
    check("drain_out_valid", out_valid, 0);
    check("drain_out_data", out_data, 32'h5555_5555);

    // backpressure
    b_valid = 1'b1; b_data = 32'hDEAD_BEEF;
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    step();
    b_valid = 1'b0;
    out_ready = 1'b0;
    a_valid = 1'b1; a_data = 32'h0000_CAFE;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_a_ready", a_ready, 0);
      step();
      check("bp_out_data", out_data, 32'hDEAD_BEEF);
      check("bp_out_src", out_src, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_a_ready", a_ready, 1);
    exp_q.push_back({1'b0, 32'h0000_CAFE});
    step();
    a_valid = 1'b0;
    check("bp_new_data", out_data, 32'h0000_CAFE);
    check("bp_new_src", out_src, 0);
    step();

    // saturation and clear
    do_reset();
    out_ready = 1'b1;
    a_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_data = 32'h100 + i;
      exp_q.push_back({1'b0, 32'h100 + i});
      step();
      if (i == 14) check("sat_cnt_at_15", grant_cnt_a, 15);
    end
    check("sat_cnt_hold", grant_cnt_a, 15);
    cnt_clr = 1'b1;
    a_data = 32'h0000_0200;
    exp_q.push_back({1'b0, 32'h0000_0200});
    step();
    cnt_clr = 1'b0;
    a_valid = 1'b0;
    check("clr_cnt_a", grant_cnt_a, 0);
    check("clr_cnt_b", grant_cnt_b, 0);
    step();

    // async reset while FULL
    do_reset();
    b_valid = 1'b1; b_data = 32'h0BAD_F00D;
    exp_q.push_back({1'b1, 32'h0BAD_F00D});
    step();
    b_valid = 1'b0;
    out_ready = 1'b0;
    check("ar_full", out_valid, 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("ar_out_valid_now", out_valid, 0);
    check("ar_out_data_now", out_data, 0);
    step();
    rst = 1'b0;
    a_valid = 1'b1; a_data = 32'h1111_1111;
    b_valid = 1'b1; b_data = 32'h2222_2222;
    out_ready = 1'b1;
    #1;
    check("ar_first_a_ready", a_ready, 1);
    check("ar_first_b_ready", b_ready, 0);
    exp_q.push_back({1'b0, 32'h1111_1111});
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    check("ar_first_src", out_src, 0);
    step();
    step();

    // final report
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_arbiter.md
Name: alu_operand_arbiter

Overview:
- Shares the single 32-bit ALU operand path between two requesters (A, B).
- Each requester presents a valid/ready channel. The block picks one per cycle round-robin and steers its data with a 2:1 32-bit mux.
- The winner's data is captured into a one-entry output register, which feeds the ALU over a valid/ready channel.
- Sits between the decode/forwarding sources and the ALU operand input.

Parameters:
- DATA_W, 32, operand width; must stay 32 to match the mux.
- CNT_W, 16, width of the per-requester grant counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has an operand.
- a_data  in  32  requester A operand.
- a_ready  out  1  A transfer accepted this cycle.
- b_valid  in  1  requester B has an operand.
- b_data  in  32  requester B operand.
- b_ready  out  1  B transfer accepted this cycle.
- out_valid  out  1  output register holds an operand.
- out_data  out  32  registered operand.
- out_src  out  1  source of out_data: 0 = A, 1 = B.
- out_ready  in  1  ALU consumes out_data this cycle.
- cnt_clr  in  1  synchronous clear of both grant counters.
- grant_cnt_a  out  CNT_W  saturating count of A grants.
- grant_cnt_b  out  CNT_W  saturating count of B grants.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_src=0, last_src=1 (A has priority first), grant counters=0. a_ready and b_ready are 0 while rst is asserted.
- State machine, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_load = (state==EMPTY) | out_ready.
- Arbitration (combinational):
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the side opposite last_src.
  - Neither valid -> no grant.
- a_ready = grant_A & can_load; b_ready = grant_B & can_load. At most one ready is high per cycle. Ready may depend on valid; valid must not depend on ready.
- Load, on a cycle with any grant & can_load:
  - out_data <= selected data via mux (sel = grant_B).
  - out_src <= grant_B; last_src <= grant_B.
  - State -> FULL.
  - The granted counter increments, saturating at 2^CNT_W-1.
- Drain: FULL & out_ready & no grant -> EMPTY, out_valid=0 next cycle. out_data holds its last value (no clearing).
- Simultaneous drain and load: FULL & out_ready & grant -> stays FULL with new data. This sustains one operand per cycle with no bubble.
- Backpressure: FULL & ~out_ready -> out_data and out_src hold, both readies stay 0, last_src unchanged. Arbitration resumes on the first cycle out_ready=1.
- Latency: operand accepted in cycle N appears on out_data with out_valid=1 in cycle N+1.
- Fairness: with both requesters continuously valid and out_ready=1, grants alternate strictly A, B, A, B ... starting with A after reset.
- Counters:
  - cnt_clr has priority over increment in the same cycle; counters read 0 the next cycle.
  - Saturation holds at the maximum value; no wrap to 0.
- Reset mid-transfer: any pending out_valid is dropped immediately (asynchronously). No partial operand is ever presented. After reset release, arbitration restarts with A priority.
- Inputs a_data and b_data are only sampled on the cycle their ready is high.

Decomposition:
- Shared package constant: DATA_W=32.
- Shared package constants for source encoding: SRC_A=0, SRC_B=1.
- State encoding constants: ST_EMPTY=0, ST_FULL=1.
- Data steering instantiates the existing 2:1 32-bit gate-level mux, mux2w32, with sel tied to grant_B. No new datapath module is created.
- Arbitration logic and counters stay in this module.

Test Plan:
- Reset, then A only: a_valid=1, a_data=0x0000_1234, out_ready=1 -> a_ready=1 in cycle 0; cycle 1 out_valid=1, out_data=0x0000_1234, out_src=0, grant_cnt_a=1.
- Both valid continuously: a_data=0xAAAA_AAAA, b_data=0x5555_5555, out_ready=1 for 6 cycles -> out_src sequence 0,1,0,1,0,1 with no bubbles; grant_cnt_a=3, grant_cnt_b=3.
- Backpressure: load B=0xDEAD_BEEF, then out_ready=0 for 3 cycles with A valid -> out_data stays 0xDEAD_BEEF, a_ready=0 for all 3 cycles. When out_ready=1, A is accepted the same cycle and out_data=A's value the next cycle.
- Drain to empty: FULL, out_ready=1, no valids -> out_valid=0 the next cycle; out_data keeps its last value.
- Saturation/clear: CNT_W=4, run 20 A grants -> grant_cnt_a=15 (holds). Then assert cnt_clr together with an A grant -> grant_cnt_a=0.
- Async reset mid-stream: assert rst between clock edges while FULL -> out_valid=0 immediately. After release with both valid, the first grant is A.
